// File: rtl/serial_adc_scanner.sv
// Round-robin scanner for N_CH TLC549-style serial ADCs on a shared clock/data bus.
// Each word is delivered with its channel tag, a valid pulse and a stale qualifier.
module serial_adc_scanner #(
    parameter int DATA_W      = 8,
    parameter int N_CH        = 3,
    parameter int CH_W        = 2,
    parameter int CLK_DIV     = 42,
    parameter int CS_SETUP    = 83,
    parameter int CONV_CYCLES = 834,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              single,
    input  logic              data_in,
    output logic              ADC_clk,
    output logic [N_CH-1:0]   CS,
    output logic [DATA_W-1:0] ADC_value,
    output logic [CH_W-1:0]   ADC_ch,
    output logic              value_valid,
    output logic              stale,
    output logic              frame_done,
    output logic              busy
);

    localparam int MAX_A   = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int MAX_CNT = (MAX_A > CONV_CYCLES) ? MAX_A : CONV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  CS_ONE     = N_CH'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        CONV
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CH_W-1:0]   ptr;
    logic [DATA_W-1:0] shreg;
    logic [N_CH-1:0]   seen;
    logic              single_mode;

    logic              last_ch;
    logic [CH_W-1:0]   next_ptr;
    logic [N_CH-1:0]   cs_cur;
    logic [N_CH-1:0]   cs_next;
    logic              go_idle;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        last_ch  = (ptr == CH_LAST);
        next_ptr = last_ch ? '0 : ptr + 1'b1;
        cs_cur   = ~(CS_ONE << ptr);
        cs_next  = ~(CS_ONE << next_ptr);
        // Continuous mode wins whenever enable is high, even mid single frame.
        go_idle  = enable ? 1'b0 : (single_mode ? last_ch : 1'b1);
        if (MSB_FIRST)
            shifted = {shreg[DATA_W-2:0], data_in};
        else
            shifted = {data_in, shreg[DATA_W-1:1]};
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            ptr         <= '0;
            shreg       <= '0;
            seen        <= '0;
            single_mode <= 1'b0;
            ADC_clk     <= 1'b0;
            CS          <= '1;
            ADC_value   <= '0;
            ADC_ch      <= '0;
            value_valid <= 1'b0;
            stale       <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            stale       <= 1'b0;
            frame_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable || single) begin
                        single_mode <= ~enable;
                        state       <= SETUP;
                        CS          <= cs_cur;
                        cnt         <= '0;
                        busy        <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= HIGH;
                        ADC_clk <= 1'b1;
                        shreg   <= shifted;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        state   <= LOW;
                        ADC_clk <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        cnt         <= '0;
                        state       <= CONV;
                        CS          <= '1;
                        ADC_value   <= shreg;
                        ADC_ch      <= ptr;
                        value_valid <= 1'b1;
                        stale       <= ~seen[ptr];
                        seen[ptr]   <= 1'b1;
                        frame_done  <= last_ch;
                    end else begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= HIGH;
                        ADC_clk <= 1'b1;
                        shreg   <= shifted;
                    end
                end
                CONV: begin
                    if (cnt == CONV_LAST) begin
                        cnt <= '0;
                        ptr <= next_ptr;
                        if (enable)
                            single_mode <= 1'b0;
                        if (go_idle) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= SETUP;
                            CS    <= cs_next;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
